// File: rtl/alu_response_checker.sv
// alu_response_checker: recomputes each ALU transaction, compares it to the ALU's result, counts outcomes, and captures the first failure
module alu_response_checker #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [2:0]       in_ALUop,
    input  logic [WIDTH-1:0] in_operand_1,
    input  logic [WIDTH-1:0] in_operand_2,
    input  logic [WIDTH-1:0] in_result,
    output logic [CNT_W-1:0] check_count,
    output logic [CNT_W-1:0] error_count,
    output logic [CNT_W-1:0] illegal_count,
    output logic             mismatch,
    output logic             error,
    output logic             ff_valid,
    output logic [2:0]       ff_ALUop,
    output logic [WIDTH-1:0] ff_operand_1,
    output logic [WIDTH-1:0] ff_operand_2,
    output logic [WIDTH-1:0] ff_result,
    output logic [WIDTH-1:0] ff_expected
);
    logic [WIDTH-1:0] exp_c;
    logic             s1_valid;
    logic [2:0]       s1_op;
    logic [WIDTH-1:0] s1_a, s1_b, s1_res, s1_exp;
    logic             s1_legal, s1_illegal, s1_fail;
    always_comb begin
        exp_c = '0;
        case (in_ALUop)
            3'b000: exp_c = in_operand_1 + in_operand_2;
            3'b001: exp_c = in_operand_1 - in_operand_2;
            3'b010: exp_c = in_operand_1 | in_operand_2;
            3'b011: exp_c = in_operand_1 & in_operand_2;
            3'b100: exp_c = in_operand_1 ^ in_operand_2;
            3'b101: exp_c = {{(WIDTH-1){1'b0}}, $signed(in_operand_1) < $signed(in_operand_2)};
            3'b110: exp_c = {{(WIDTH-1){1'b0}}, in_operand_1 < in_operand_2};
            default: exp_c = '0;
        endcase
    end
    assign s1_illegal = s1_valid && s1_op == 3'b111;
    assign s1_legal   = s1_valid && s1_op != 3'b111;
    assign s1_fail    = s1_legal && s1_res != s1_exp;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_res   <= '0;
            s1_exp   <= '0;
        end else if (clear) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_res   <= '0;
            s1_exp   <= '0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_op  <= in_ALUop;
                s1_a   <= in_operand_1;
                s1_b   <= in_operand_2;
                s1_res <= in_result;
                s1_exp <= exp_c;
            end
        end
    end
    // counters saturate; saturation never masks error or the first-fail capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            check_count   <= '0;
            error_count   <= '0;
            illegal_count <= '0;
            mismatch      <= 1'b0;
            error         <= 1'b0;
            ff_valid      <= 1'b0;
            ff_ALUop      <= '0;
            ff_operand_1  <= '0;
            ff_operand_2  <= '0;
            ff_result     <= '0;
            ff_expected   <= '0;
        end else if (clear) begin
            check_count   <= '0;
            error_count   <= '0;
            illegal_count <= '0;
            mismatch      <= 1'b0;
            error         <= 1'b0;
            ff_valid      <= 1'b0;
            ff_ALUop      <= '0;
            ff_operand_1  <= '0;
            ff_operand_2  <= '0;
            ff_result     <= '0;
            ff_expected   <= '0;
        end else begin
            check_count   <= check_count + CNT_W'(s1_legal && !(&check_count));
            error_count   <= error_count + CNT_W'(s1_fail && !(&error_count));
            illegal_count <= illegal_count + CNT_W'(s1_illegal && !(&illegal_count));
            mismatch      <= s1_fail;
            error         <= error | s1_fail;
            if (s1_fail && !ff_valid) begin
                ff_valid     <= 1'b1;
                ff_ALUop     <= s1_op;
                ff_operand_1 <= s1_a;
                ff_operand_2 <= s1_b;
                ff_result    <= s1_res;
                ff_expected  <= s1_exp;
            end
        end
    end
endmodule

// File: tb/tb_alu_response_checker.sv
// tb_alu_response_checker: table-driven vectors with a scoreboard of expected mismatch pulses
module tb_alu_response_checker;
    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        mm;
    } vec_t;

    logic        clk, rst_n, clear, in_valid;
    logic [2:0]  in_ALUop;
    logic [31:0] in_operand_1, in_operand_2, in_result;
    logic [15:0] check_count, error_count, illegal_count;
    logic        mismatch, error, ff_valid;
    logic [2:0]  ff_ALUop;
    logic [31:0] ff_operand_1, ff_operand_2, ff_result, ff_expected;
    logic [1:0]  s_check, s_error_count, s_illegal;
    logic        s_mismatch, s_error, s_ff_valid;
    logic [2:0]  s_ff_ALUop;
    logic [31:0] s_ff_op1, s_ff_op2, s_ff_res, s_ff_exp;

    int   n_cmp = 0;
    int   n_err = 0;
    bit   pend;
    logic cl, nv, e;
    bit   sb[$];
    vec_t legal_v[7];
    vec_t fail_v;

    alu_response_checker #(.WIDTH(32), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
        .in_ALUop(in_ALUop), .in_operand_1(in_operand_1), .in_operand_2(in_operand_2),
        .in_result(in_result), .check_count(check_count), .error_count(error_count),
        .illegal_count(illegal_count), .mismatch(mismatch), .error(error),
        .ff_valid(ff_valid), .ff_ALUop(ff_ALUop), .ff_operand_1(ff_operand_1),
        .ff_operand_2(ff_operand_2), .ff_result(ff_result), .ff_expected(ff_expected)
    );

    alu_response_checker #(.WIDTH(32), .CNT_W(2)) dut_small (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
        .in_ALUop(in_ALUop), .in_operand_1(in_operand_1), .in_operand_2(in_operand_2),
        .in_result(in_result), .check_count(s_check), .error_count(s_error_count),
        .illegal_count(s_illegal), .mismatch(s_mismatch), .error(s_error),
        .ff_valid(s_ff_valid), .ff_ALUop(s_ff_ALUop), .ff_operand_1(s_ff_op1),
        .ff_operand_2(s_ff_op2), .ff_result(s_ff_res), .ff_expected(s_ff_exp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v, input logic clr);
        @(negedge clk);
        in_valid     = 1'b1;
        in_ALUop     = v.op;
        in_operand_1 = v.a;
        in_operand_2 = v.b;
        in_result    = v.r;
        clear        = clr;
        if (!clr) sb.push_back(v.mm);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            clear    = 1'b0;
        end
    endtask

    // scoreboard: each transaction accepted at edge k is due as a mismatch pulse after edge k+1
    always @(posedge clk) begin
        cl = clear;
        nv = in_valid & ~clear & rst_n;
        #1;
        e = 1'b0;
        if (pend) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL scoreboard: got empty queue expected an entry");
            end else e = sb.pop_front();
        end
        chk("mismatch", {31'b0, mismatch}, {31'b0, cl ? 1'b0 : e});
        pend = nv;
    end

    initial begin
        legal_v[0] = '{3'b000, 32'd5, 32'd6, 32'd11, 1'b0};
        legal_v[1] = '{3'b001, 32'd7, 32'd3, 32'd4, 1'b0};
        legal_v[2] = '{3'b010, 32'd3, 32'd1, 32'd3, 1'b0};
        legal_v[3] = '{3'b011, 32'd3, 32'd5, 32'd1, 1'b0};
        legal_v[4] = '{3'b100, 32'd5, 32'd2, 32'd7, 1'b0};
        legal_v[5] = '{3'b101, 32'hFFFFFFFA, 32'd4, 32'd1, 1'b0};
        legal_v[6] = '{3'b110, 32'd5, 32'd6, 32'd1, 1'b0};
        fail_v     = '{3'b000, 32'd1, 32'd1, 32'd0, 1'b1};
        pend = 1'b0;
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0;
        in_ALUop = '0; in_operand_1 = '0; in_operand_2 = '0; in_result = '0;
        repeat (2) @(negedge clk);
        chk("rst check_count", 32'(check_count), 0);
        chk("rst error_count", 32'(error_count), 0);
        chk("rst illegal_count", 32'(illegal_count), 0);
        chk("rst error", {31'b0, error}, 0);
        chk("rst ff_valid", {31'b0, ff_valid}, 0);
        chk("rst ff_result", ff_result, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) drive(legal_v[i], 1'b0);
        idle(2);
        chk("legal check_count", 32'(check_count), 7);
        chk("legal error_count", 32'(error_count), 0);
        chk("legal error", {31'b0, error}, 0);
        chk("legal ff_valid", {31'b0, ff_valid}, 0);

        drive('{3'b000, 32'd5, 32'd6, 32'd12, 1'b1}, 1'b0);
        drive('{3'b001, 32'd7, 32'd3, 32'd0, 1'b1}, 1'b0);
        idle(2);
        chk("fail error_count", 32'(error_count), 2);
        chk("fail check_count", 32'(check_count), 9);
        chk("fail error", {31'b0, error}, 1);
        chk("ff_valid", {31'b0, ff_valid}, 1);
        chk("ff_ALUop", {29'b0, ff_ALUop}, 0);
        chk("ff_operand_1", ff_operand_1, 5);
        chk("ff_operand_2", ff_operand_2, 6);
        chk("ff_result", ff_result, 12);
        chk("ff_expected", ff_expected, 11);

        drive('{3'b101, 32'hFFFFFFFA, 32'd4, 32'd1, 1'b0}, 1'b0);
        drive('{3'b110, 32'hFFFFFFFA, 32'd4, 32'd0, 1'b0}, 1'b0);
        drive('{3'b101, 32'hFFFFFFFA, 32'd4, 32'd0, 1'b1}, 1'b0);
        drive('{3'b111, 32'd9, 32'd2, 32'd77, 1'b0}, 1'b0);
        idle(2);
        chk("sgn error_count", 32'(error_count), 3);
        chk("sgn check_count", 32'(check_count), 12);
        chk("illegal_count", 32'(illegal_count), 1);
        chk("ff_result kept", ff_result, 12);

        drive(fail_v, 1'b0);
        drive(fail_v, 1'b1);
        idle(1);
        chk("clr check_count", 32'(check_count), 0);
        chk("clr error_count", 32'(error_count), 0);
        chk("clr illegal_count", 32'(illegal_count), 0);
        chk("clr error", {31'b0, error}, 0);
        chk("clr ff_valid", {31'b0, ff_valid}, 0);
        chk("clr ff_result", ff_result, 0);
        drive('{3'b000, 32'd2, 32'd3, 32'd5, 1'b0}, 1'b0);
        idle(2);
        chk("post-clr check_count", 32'(check_count), 1);
        chk("post-clr error_count", 32'(error_count), 0);

        for (int i = 0; i < 6; i++) drive(fail_v, 1'b0);
        idle(2);
        chk("big error_count", 32'(error_count), 6);
        chk("big check_count", 32'(check_count), 7);
        chk("sat error_count", 32'(s_error_count), 3);
        chk("sat check_count", 32'(s_check), 3);
        chk("sat error", {31'b0, s_error}, 1);
        chk("sat ff_valid", {31'b0, s_ff_valid}, 1);

        drive('{3'b000, 32'd1, 32'd1, 32'd2, 1'b0}, 1'b0);
        drive('{3'b000, 32'd1, 32'd1, 32'd9, 1'b1}, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("arst check_count", 32'(check_count), 0);
        chk("arst error_count", 32'(error_count), 0);
        chk("arst error", {31'b0, error}, 0);
        chk("arst ff_valid", {31'b0, ff_valid}, 0);
        sb.delete();
        pend = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drive('{3'b011, 32'hF0, 32'h3C, 32'h30, 1'b0}, 1'b0);
        idle(2);
        chk("post-rst check_count", 32'(check_count), 1);
        chk("post-rst error_count", 32'(error_count), 0);
        chk("post-rst error", {31'b0, error}, 0);
        idle(1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
